log_dump_reader: RTL and testbench
==================================

# log_dump_reader

Reader side of the access-log BRAM. The GDP side writes one 24-bit entry (type[23:16], address[15:0]) per bus access. On command, this block reads a run of those entries through the BRAM user port, splits each entry into three bytes and streams them over a ready/valid byte interface to the UART transmit path of the control interface. It sits in the 50 MHz control domain, between the control interface's command decoder and the log storage user port.

## Interface
Parameters:
- ADDR_WIDTH, 10, log BRAM address width; depth = 2^ADDR_WIDTH entries
- DATA_WIDTH, 24, entry width; fixed at 24 (three bytes), other values unsupported

Ports:
- clk  in  1  control clock (50 MHz); one clock only
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- abort  in  1  terminate the dump in progress
- first_addr  in  ADDR_WIDTH  address of the first entry; sampled with start
- count  in  ADDR_WIDTH+1  number of entries; sampled with start
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse when the dump completes normally
- log_addr  out  ADDR_WIDTH  BRAM read address
- log_rd  out  1  one-cycle BRAM read strobe
- log_data  in  DATA_WIDTH  BRAM read data
- log_data_valid  in  1  read data valid strobe
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  downstream accepts the byte this cycle

## Operation
- States: IDLE, READ, WAIT, SEND, NEXT, DONE.
- IDLE: on start & !abort, latch first_addr into addr_q. Latch min(count, 2^ADDR_WIDTH) into remaining.
  - If the latched count is 0, go to DONE.
  - Otherwise go to READ.
- READ: drive log_rd=1 for exactly one cycle with log_addr=addr_q, then go to WAIT.
- WAIT: hold log_addr. On log_data_valid, latch log_data into entry_q, set byte_idx=0 and go to SEND. There is no timeout; abort is the only exit.
- SEND: tx_valid=1. tx_data is byte byte_idx of entry_q, MSB first: 0 = [23:16], 1 = [15:8], 2 = [7:0].
  - On tx_valid & tx_ready: if byte_idx=2, go to NEXT; otherwise increment byte_idx.
- NEXT: decrement remaining.
  - If the result is 0, go to DONE.
  - Otherwise addr_q = addr_q + 1 modulo 2^ADDR_WIDTH, then go to READ.
- DONE: assert done for one cycle, then go to IDLE.
- log_data_valid outside WAIT is ignored.
- start outside IDLE is ignored.
- abort in any non-IDLE state: next state is IDLE; tx_valid and log_rd deassert next cycle, and done is not pulsed. A partially sent entry is discarded.
- abort & start together in IDLE: start is ignored.

## Timing
- Reset values: busy=0, done=0, log_rd=0, log_addr=0, tx_valid=0, tx_data=0. State is IDLE, byte_idx=0, remaining=0.
- All outputs are registered.
- Start sampled in cycle T: busy=1 and log_rd=1 in cycle T+1.
- BRAM read latency L (cycles from log_rd to log_data_valid) may be any value ≥1.
- First tx_valid appears one cycle after log_data_valid.
- Ready/valid rules:
  - tx_data is stable while tx_valid & !tx_ready.
  - tx_valid never drops without acceptance, except on abort or reset.
  - With tx_ready held high, the three bytes take 3 consecutive cycles.
- Per entry, with tx_ready=1: 1 (READ) + L (WAIT) + 3 (SEND) + 1 (NEXT) cycles.
- done is asserted in the cycle after the NEXT cycle of the final entry. busy falls in the cycle after done.
- Count=0: done is asserted in T+1; no log_rd or tx_valid is issued.
- Wrap: first_addr = 2^ADDR_WIDTH−1 with count=2 reads addresses 1023, then 0.
- Asynchronous reset mid-dump forces the reset values immediately.

## Structure
- Shared package log_pkg holds:
  - LOG_ENTRY_W=24
  - the entry field offsets (TYPE_MSB=23, TYPE_LSB=16, ADDR_MSB=15, ADDR_LSB=0)
  - LOG_BYTES_PER_ENTRY=3
  - the state enumeration
- The bram_log writer uses the same field offsets.
- One sub-module is natural: entry_serializer. It covers the SEND state and holds entry_q, byte_idx and the ready/valid logic. It takes load and entry and returns last_byte_accepted. The FSM and address counter stay in the top.

## Test plan
- first_addr=0x010, count=2, BRAM holds 0x12ABCD and 0x345678, L=1, tx_ready=1 -> bytes 12 AB CD 34 56 78 on consecutive accepted cycles, one done pulse, log_addr sequence 0x010, 0x011.
- count=0 -> done in T+1, no log_rd, no tx_valid.
- first_addr=0x3FF, count=3 -> reads at 0x3FF, 0x000, 0x001. count=0x7FF clamps to 1024 reads.
- tx_ready toggling randomly, L=3 -> tx_data stable whenever tx_valid & !tx_ready, byte order preserved, stray log_data_valid outside WAIT ignored.
- abort while in SEND on byte 1 -> next cycle IDLE, tx_valid=0, busy=0, no done. A subsequent start runs normally.
- start asserted while busy, and start+abort together in IDLE -> both ignored, no state change.

Source files
------------

// File: rtl/log_pkg.sv
// Shared definitions for the access-log BRAM: entry layout, byte split and
// the reader state encoding.
package log_pkg;

  localparam int LOG_ENTRY_W         = 24;
  localparam int TYPE_MSB            = 23;
  localparam int TYPE_LSB            = 16;
  localparam int ADDR_MSB            = 15;
  localparam int ADDR_LSB            = 0;
  localparam int LOG_BYTES_PER_ENTRY = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    NEXT,
    DONE
  } state_t;

  // Byte idx of an entry, MSB first: 0 = type, 1 = address high, 2 = address low
  function automatic logic [7:0] entry_byte(input logic [LOG_ENTRY_W-1:0] e,
                                            input logic [1:0] idx);
    case (idx)
      2'd0:    entry_byte = e[TYPE_MSB:TYPE_LSB];
      2'd1:    entry_byte = e[ADDR_MSB:ADDR_MSB-7];
      default: entry_byte = e[ADDR_LSB+7:ADDR_LSB];
    endcase
  endfunction

endpackage

// File: rtl/entry_serializer.sv
// Holds one log entry and streams its three bytes over a ready/valid
// interface, MSB first, with registered data and valid.
module entry_serializer
  import log_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic [LOG_ENTRY_W-1:0] entry,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   last_byte_accepted
);

  localparam logic [1:0] LAST_IDX = 2'(LOG_BYTES_PER_ENTRY - 1);

  logic [LOG_ENTRY_W-1:0] entry_q;
  logic [1:0]             byte_idx;

  assign last_byte_accepted = tx_valid && tx_ready && (byte_idx == LAST_IDX);

  // Load an entry, then advance one byte per accepted handshake; clear drops a partial entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q  <= '0;
      byte_idx <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (clear) begin
      byte_idx <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      entry_q  <= entry;
      byte_idx <= 2'd0;
      tx_data  <= entry_byte(entry, 2'd0);
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (byte_idx == LAST_IDX) begin
        byte_idx <= 2'd0;
        tx_valid <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        tx_data  <= entry_byte(entry_q, byte_idx + 2'd1);
      end
    end
  end

endmodule

// File: rtl/log_dump_reader.sv
// Reads a run of access-log entries from the BRAM user port and hands each
// one to the byte serializer feeding the UART transmit path.
module log_dump_reader
  import log_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic                  log_rd,
  input  logic [DATA_WIDTH-1:0] log_data,
  input  logic                  log_data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state;
  logic [ADDR_WIDTH:0] remaining;
  logic [ADDR_WIDTH:0] count_clamped;
  logic                ser_load;
  logic                ser_clear;
  logic                last_byte_accepted;

  // A request longer than the BRAM would only re-read entries, so cap it at one full pass
  assign count_clamped = (count > DEPTH) ? DEPTH : count;

  assign ser_load  = (state == WAIT) && log_data_valid && !abort;
  assign ser_clear = abort && (state != IDLE);

  // Dump sequencer: address counter, entry counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      log_addr  <= '0;
      log_rd    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      log_rd <= 1'b0;
      done   <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              log_addr  <= first_addr;
              remaining <= count_clamped;
              busy      <= 1'b1;
              if (count_clamped == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= READ;
                log_rd <= 1'b1;
              end
            end
          end
          READ: state <= WAIT;
          WAIT: begin
            if (log_data_valid) state <= SEND;
          end
          SEND: begin
            if (last_byte_accepted) state <= NEXT;
          end
          NEXT: begin
            remaining <= remaining - 1'b1;
            if (remaining == 1) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              log_addr <= log_addr + 1'b1;
              state    <= READ;
              log_rd   <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  entry_serializer u_serializer (
    .clk                (clk),
    .rst_n              (rst_n),
    .clear              (ser_clear),
    .load               (ser_load),
    .entry              (log_data),
    .tx_ready           (tx_ready),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .last_byte_accepted (last_byte_accepted)
  );

endmodule

// File: tb/tb_log_dump_reader.sv
// Directed bench for log_dump_reader with a latency-configurable BRAM model
// and a negedge monitor collecting addresses, bytes and done pulses.
module tb_log_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [9:0]  first_addr;
  logic [10:0] count;
  logic        busy;
  logic        done;
  logic [9:0]  log_addr;
  logic        log_rd;
  logic [23:0] log_data;
  logic        log_data_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // BRAM model
  logic [23:0] mem [1024];
  logic [7:0]  rd_v = '0;
  logic [9:0]  rd_a [8];
  int          lat = 1;
  logic        stray_valid = 1'b0;
  logic        stray_en = 1'b0;
  logic        rand_ready = 1'b0;

  // Monitor state
  logic [9:0]  rd_addrs [$];
  logic [7:0]  tx_bytes [$];
  int          tx_cycs [$];
  int          first_rd, first_tx, done_cnt, done_cyc, last_busy, stab_err;
  logic        stab_en = 1'b1;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = '0;
  int          t0;

  log_dump_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(24)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .first_addr     (first_addr),
    .count          (count),
    .busy           (busy),
    .done           (done),
    .log_addr       (log_addr),
    .log_rd         (log_rd),
    .log_data       (log_data),
    .log_data_valid (log_data_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read pipeline: data for a strobe seen at edge k appears lat cycles after the strobe
  always @(posedge clk) begin
    rd_v <= {rd_v[6:0], log_rd};
    for (int i = 7; i > 0; i--) rd_a[i] <= rd_a[i-1];
    rd_a[0] <= log_addr;
  end

  assign log_data_valid = rd_v[lat-1] | stray_valid;
  assign log_data       = stray_valid ? 24'hEEEEEE : mem[rd_a[lat-1]];

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    stray_valid = stray_en && tx_valid && ($urandom_range(0, 2) == 0);
  end

  // Observe everything at the falling edge, away from DUT updates
  always @(negedge clk) begin
    if (rst_n) begin
      if (log_rd) begin
        rd_addrs.push_back(log_addr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (tx_valid && first_tx < 0) first_tx = cyc;
      if (tx_valid && tx_ready) begin
        tx_bytes.push_back(tx_data);
        tx_cycs.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) last_busy = cyc;
      if (stab_en && prev_hold && (!tx_valid || tx_data != prev_data)) stab_err++;
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearMon();
    rd_addrs.delete();
    tx_bytes.delete();
    tx_cycs.delete();
    first_rd  = -1;
    first_tx  = -1;
    done_cnt  = 0;
    done_cyc  = -1;
    last_busy = -1;
    stab_err  = 0;
    prev_hold = 1'b0;
  endtask

  task automatic applyStimulus(input logic [9:0] fa, input logic [10:0] cnt, output int t);
    @(posedge clk); #1;
    first_addr = fa;
    count      = cnt;
    start      = 1'b1;
    t          = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(n < maxc), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] expByte(input logic [23:0] e, input int idx);
    logic [23:0] s;
    s = e >> (16 - 8 * idx);
    return s[7:0];
  endfunction

  // Compare the captured byte stream against entries read from addresses base, base+1, ...
  task automatic checkBytes(input string tag, input logic [9:0] base, input int n);
    logic [9:0] a;
    checkOutput({tag, "_nbytes"}, 64'(tx_bytes.size()), 64'(3 * n));
    for (int e = 0; e < n; e++) begin
      a = base + 10'(e);
      for (int b = 0; b < 3; b++)
        if (3 * e + b < tx_bytes.size())
          checkOutput($sformatf("%s_b%0d", tag, 3 * e + b), 64'(tx_bytes[3*e+b]),
                      64'(expByte(mem[a], b)));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {8'(i) ^ 8'hA5, 16'(i * 3 + 'h1000)};
    mem[16] = 24'h12ABCD;
    mem[17] = 24'h345678;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    first_addr = '0; count = '0; tx_ready = 1'b1;
    clearMon();

    // Reset values
    #15;
    checkOutput("reset_outs", 64'({busy, done, log_rd, tx_valid, log_addr, tx_data}), 64'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic two-entry dump with exact cycle timing
    clearMon();
    applyStimulus(10'h010, 11'd2, t0);
    waitIdle("basic_timeout", 100);
    checkOutput("basic_first_rd", 64'(first_rd - t0), 64'd1);
    checkOutput("basic_first_tx", 64'(first_tx - t0), 64'd3);
    checkOutput("basic_nrd", 64'(rd_addrs.size()), 64'd2);
    if (rd_addrs.size() == 2)
      checkOutput("basic_addrs", 64'({rd_addrs[0], rd_addrs[1]}), 64'({10'h010, 10'h011}));
    checkOutput("basic_bytes", 64'(tx_bytes.size() == 6 ?
                {tx_bytes[0], tx_bytes[1], tx_bytes[2], tx_bytes[3], tx_bytes[4], tx_bytes[5]} : 48'd0),
                64'h12ABCD345678);
    if (tx_cycs.size() == 6)
      checkOutput("basic_tx_cycs", 64'({8'(tx_cycs[0] - t0), 8'(tx_cycs[2] - t0),
                                        8'(tx_cycs[3] - t0), 8'(tx_cycs[5] - t0)}),
                  64'({8'd3, 8'd5, 8'd9, 8'd11}));
    checkOutput("basic_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("basic_done_cyc", 64'(done_cyc - t0), 64'd13);
    checkOutput("basic_busy_end", 64'(last_busy - t0), 64'd13);

    // Zero-length dump
    clearMon();
    applyStimulus(10'h055, 11'd0, t0);
    waitIdle("zero_timeout", 20);
    checkOutput("zero_done_cyc", 64'(done_cyc - t0), 64'd1);
    checkOutput("zero_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("zero_nrd_ntx", 64'({16'(rd_addrs.size()), 16'(first_tx < 0 ? 0 : 1)}), 64'd0);
    checkOutput("zero_busy_end", 64'(last_busy - t0), 64'd1);

    // Address wrap at the top of the BRAM
    clearMon();
    applyStimulus(10'h3FF, 11'd3, t0);
    waitIdle("wrap_timeout", 100);
    checkOutput("wrap_nrd", 64'(rd_addrs.size()), 64'd3);
    if (rd_addrs.size() == 3)
      checkOutput("wrap_addrs", 64'({rd_addrs[0], rd_addrs[1], rd_addrs[2]}),
                  64'({10'h3FF, 10'h000, 10'h001}));
    checkBytes("wrap", 10'h3FF, 3);

    // Oversized count clamps to one full pass of the BRAM
    clearMon();
    applyStimulus(10'h200, 11'h7FF, t0);
    waitIdle("clamp_timeout", 8000);
    checkOutput("clamp_nrd", 64'(rd_addrs.size()), 64'd1024);
    if (rd_addrs.size() == 1024)
      checkOutput("clamp_ends", 64'({rd_addrs[0], rd_addrs[1023]}), 64'({10'h200, 10'h1FF}));
    checkOutput("clamp_ntx", 64'(tx_bytes.size()), 64'd3072);
    checkOutput("clamp_done_cnt", 64'(done_cnt), 64'd1);

    // Random backpressure, latency 3, stray valid strobes during SEND
    clearMon();
    lat = 3;
    rand_ready = 1'b1;
    stray_en = 1'b1;
    applyStimulus(10'h020, 11'd4, t0);
    waitIdle("rand_timeout", 500);
    rand_ready = 1'b0;
    stray_en = 1'b0;
    tx_ready = 1'b1;
    checkOutput("rand_first_tx", 64'(first_tx - t0), 64'd5);
    checkBytes("rand", 10'h020, 4);
    checkOutput("rand_stable", 64'(stab_err), 64'd0);
    checkOutput("rand_done_cnt", 64'(done_cnt), 64'd1);
    lat = 1;

    // Abort while byte 1 of the first entry is pending
    clearMon();
    stab_en = 1'b0;
    tx_ready = 1'b0;
    applyStimulus(10'h030, 11'd2, t0);
    begin
      int n = 0;
      while (!tx_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("abort_wait_tx", 64'(n < 50), 64'd1);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    checkOutput("abort_byte1", 64'({tx_valid, tx_data}), 64'({1'b1, expByte(mem[10'h030], 1)}));
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    checkOutput("abort_outs", 64'({busy, tx_valid, log_rd}), 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", 64'({done_cnt, 16'(rd_addrs.size())}), 64'({32'd0, 16'd1}));
    stab_en = 1'b1;

    // A fresh dump after the abort runs normally
    clearMon();
    applyStimulus(10'h040, 11'd1, t0);
    waitIdle("after_abort_timeout", 100);
    checkBytes("after_abort", 10'h040, 1);
    checkOutput("after_abort_done", 64'(done_cnt), 64'd1);

    // start while busy is ignored
    clearMon();
    applyStimulus(10'h050, 11'd2, t0);
    repeat (2) @(posedge clk); #1;
    first_addr = 10'h100;
    count = 11'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle("busy_start_timeout", 100);
    checkOutput("busy_start_nrd", 64'(rd_addrs.size()), 64'd2);
    if (rd_addrs.size() == 2)
      checkOutput("busy_start_addrs", 64'({rd_addrs[0], rd_addrs[1]}), 64'({10'h050, 10'h051}));
    checkBytes("busy_start", 10'h050, 2);
    checkOutput("busy_start_done", 64'(done_cnt), 64'd1);

    // start together with abort in IDLE is ignored
    clearMon();
    @(posedge clk); #1;
    first_addr = 10'h070; count = 11'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checkOutput("start_abort_outs", 64'({busy, log_rd, done}), 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("start_abort_quiet", 64'({16'(rd_addrs.size()), 16'(done_cnt), 16'(tx_bytes.size())}), 64'd0);

    // Asynchronous reset in the middle of a dump
    clearMon();
    applyStimulus(10'h060, 11'd3, t0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outs", 64'({busy, done, log_rd, tx_valid, log_addr, tx_data}), 64'd0);
    #5 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
